// File: rtl/gate_sweep_if.sv
// Bundles the sweep handshake and the gate-facing pins.
// The master side is the environment that requests a sweep and provides Y;
// the slave side is gate_sweep_ctrl.
// GATE_SWEEP_FAIL_LOG_EN adds the per-vector FAIL_VEC log.
interface gate_sweep_if;
  logic       START;
  logic       Y;
  logic       A;
  logic       B;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [2:0] ERR_CNT;
  logic [1:0] VEC_IDX;
`ifdef GATE_SWEEP_FAIL_LOG_EN
  logic [3:0] FAIL_VEC;

  modport master (output START, Y,
                  input  A, B, BUSY, DONE, PASS, ERR_CNT, VEC_IDX, FAIL_VEC);
  modport slave  (input  START, Y,
                  output A, B, BUSY, DONE, PASS, ERR_CNT, VEC_IDX, FAIL_VEC);
`else
  modport master (output START, Y,
                  input  A, B, BUSY, DONE, PASS, ERR_CNT, VEC_IDX);
  modport slave  (input  START, Y,
                  output A, B, BUSY, DONE, PASS, ERR_CNT, VEC_IDX);
`endif
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Clocked stimulus sequencer for a 2-input AND gate.
// Walks {A,B} through 00,01,10,11, holding each vector HOLD_CYCLES clocks,
// checks Y on the last hold cycle of each vector, then pulses DONE and
// reports ERR_CNT / PASS. All outputs are registered.
// Optional: GATE_SWEEP_FAIL_LOG_EN enables the sticky FAIL_VEC log.
module gate_sweep_ctrl #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic         CLK,
  input  logic         RST_N,
  gate_sweep_if.slave  bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    err_q, err_d;
  logic          pass_q, pass_d;
  logic          a_q, a_d, b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef GATE_SWEEP_FAIL_LOG_EN
  logic [3:0]    fail_q, fail_d;
`endif

  logic at_last;
  logic mismatch;

  // Y is checked against the registered vector, so the final vector's
  // result lands on the same edge that enters FIN and PASS can include it.
  assign at_last  = (hold_q == HOLD_LAST);
  assign mismatch = (bus.Y != (vec_q[1] & vec_q[0]));

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pass_d  = pass_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef GATE_SWEEP_FAIL_LOG_EN
    fail_d  = fail_q;
`endif
    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.START) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          hold_d  = '0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef GATE_SWEEP_FAIL_LOG_EN
          fail_d  = 4'd0;
`endif
        end
      end
      DRIVE: begin
        hold_d = hold_q + 1'b1;
        if (at_last) begin
          hold_d = '0;
          if (mismatch) begin
            err_d = err_q + 3'd1;
`ifdef GATE_SWEEP_FAIL_LOG_EN
            fail_d[vec_q] = 1'b1;
`endif
          end
          if (vec_q == 2'd3) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            a_d   = vec_d[1];
            b_d   = vec_d[0];
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset returns everything to idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      hold_q  <= '0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GATE_SWEEP_FAIL_LOG_EN
      fail_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GATE_SWEEP_FAIL_LOG_EN
      fail_q  <= fail_d;
`endif
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.PASS    = pass_q;
  assign bus.ERR_CNT = err_q;
  assign bus.VEC_IDX = vec_q;
`ifdef GATE_SWEEP_FAIL_LOG_EN
  assign bus.FAIL_VEC = fail_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: one instance with HOLD_CYCLES=100 driving a
// selectable gate model, one with HOLD_CYCLES=1 for back-to-back sweeps.
// Expected DONE records are queued when a sweep is started; monitors pop
// and compare them whenever DONE is seen.
module tb_gate_sweep_ctrl;
  localparam int H0 = 100;
  localparam int H1 = 1;

  typedef struct {
    int cyc;
    int err;
    int pass;
    int fv;
  } exp_t;

  logic CLK = 1'b0;
  logic rst0_n, rst1_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ymode = 0;   // 0 AND, 1 stuck0, 2 stuck1, 3 OR
  int   t0_0 = 0;
  int   t0_1 = 0;
  bit   active0 = 1'b0;
  exp_t sb0[$];
  exp_t sb1[$];

  gate_sweep_if b0();
  gate_sweep_if b1();

  gate_sweep_ctrl #(.HOLD_CYCLES(H0)) dut0 (.CLK(CLK), .RST_N(rst0_n), .bus(b0));
  gate_sweep_ctrl #(.HOLD_CYCLES(H1)) dut1 (.CLK(CLK), .RST_N(rst1_n), .bus(b1));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign b0.Y = (ymode == 0) ? (b0.A & b0.B) :
                (ymode == 1) ? 1'b0 :
                (ymode == 2) ? 1'b1 : (b0.A | b0.B);
  assign b1.Y = b1.A & b1.B;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_done(input string tag, input exp_t e, input int err, input int pass,
                          input int fv, input int a, input int b, input int busy);
    chk({tag, "_cycle"}, cyc, e.cyc);
    chk({tag, "_err"}, err, e.err);
    chk({tag, "_pass"}, pass, e.pass);
`ifdef GATE_SWEEP_FAIL_LOG_EN
    chk({tag, "_failvec"}, fv, e.fv);
`else
    if (fv != 0) chk({tag, "_failvec"}, fv, 0);
`endif
    chk({tag, "_ab_idle"}, {a, b} == 0 ? 0 : 1, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  function automatic int fv0();
`ifdef GATE_SWEEP_FAIL_LOG_EN
    return int'(b0.FAIL_VEC);
`else
    return 0;
`endif
  endfunction

  function automatic int fv1();
`ifdef GATE_SWEEP_FAIL_LOG_EN
    return int'(b1.FAIL_VEC);
`else
    return 0;
`endif
  endfunction

  // Monitor for the HOLD_CYCLES=100 instance: DONE scoreboard plus
  // vector stepping at the first cycle of each vector.
  always @(negedge CLK) begin
    exp_t e;
    int   n;
    if (b0.DONE) begin
      if (sb0.size() == 0) chk("done0_unexpected", 1, 0);
      else begin
        e = sb0.pop_front();
        chk_done("done0", e, int'(b0.ERR_CNT), int'(b0.PASS), fv0(),
                 int'(b0.A), int'(b0.B), int'(b0.BUSY));
      end
    end
    if (active0 && rst0_n) begin
      n = cyc - t0_0 + 1;
      if (n >= 1 && n <= 4*H0 && ((n - 1) % H0) == 0) begin
        chk("vec0_ab", int'({b0.A, b0.B}), (n - 1) / H0);
        chk("vec0_idx", int'(b0.VEC_IDX), (n - 1) / H0);
        chk("vec0_busy", int'(b0.BUSY), 1);
      end
    end
  end

  // Monitor for the HOLD_CYCLES=1 instance.
  always @(negedge CLK) begin
    exp_t e;
    if (b1.DONE) begin
      if (sb1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        e = sb1.pop_front();
        chk_done("done1", e, int'(b1.ERR_CNT), int'(b1.PASS), fv1(),
                 int'(b1.A), int'(b1.B), int'(b1.BUSY));
      end
    end
  end

  task automatic sweep0(input int err, input int pass, input int fv);
    @(negedge CLK);
    b0.START = 1'b1;
    @(posedge CLK);
    #1;
    t0_0 = cyc;
    active0 = 1'b1;
    sb0.push_back('{t0_0 + 4*H0, err, pass, fv});
    b0.START = 1'b0;
  endtask

  task automatic wait_sb0();
    for (int i = 0; i < 1000 && sb0.size() != 0; i++) @(negedge CLK);
    chk("done0_timeout", sb0.size(), 0);
    sb0.delete();
    active0 = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic wait_until0(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) @(negedge CLK);
  endtask

  initial begin
    b0.START = 1'b0;
    b1.START = 1'b0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (2) @(negedge CLK);
    // reset state
    chk("rst_a", int'(b0.A), 0);
    chk("rst_b", int'(b0.B), 0);
    chk("rst_busy", int'(b0.BUSY), 0);
    chk("rst_done", int'(b0.DONE), 0);
    chk("rst_pass", int'(b0.PASS), 0);
    chk("rst_err", int'(b0.ERR_CNT), 0);
    chk("rst_idx", int'(b0.VEC_IDX), 0);
    chk("rst_fv", fv0(), 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge CLK);

    // correct AND gate
    ymode = 0; sweep0(0, 1, 4'b0000); wait_sb0();
    // stuck at 0: only vector 3 fails
    ymode = 1; sweep0(1, 0, 4'b1000); wait_sb0();
    // stuck at 1: vectors 0..2 fail
    ymode = 2; sweep0(3, 0, 4'b0111); wait_sb0();
    // OR gate: vectors 1 and 2 fail
    ymode = 3; sweep0(2, 0, 4'b0110); wait_sb0();
    chk("pass_held", int'(b0.PASS), 0);
    chk("err_held", int'(b0.ERR_CNT), 2);

    // START during DRIVE at cycle 150 is ignored; single DONE at 401
    ymode = 0; sweep0(0, 1, 4'b0000);
    wait_until0(t0_0 + 149);
    b0.START = 1'b1;
    @(posedge CLK);
    #1;
    b0.START = 1'b0;
    wait_sb0();
    chk("no_restart_busy", int'(b0.BUSY), 0);

    // reset at cycle 250 with errors already counted
    ymode = 2; sweep0(0, 0, 0);
    wait_until0(t0_0 + 249);
    active0 = 1'b0;
    sb0.delete();
    rst0_n = 1'b0;
    #1;
    chk("mrst_a", int'(b0.A), 0);
    chk("mrst_b", int'(b0.B), 0);
    chk("mrst_busy", int'(b0.BUSY), 0);
    chk("mrst_err", int'(b0.ERR_CNT), 0);
    chk("mrst_pass", int'(b0.PASS), 0);
    chk("mrst_fv", fv0(), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    rst0_n = 1'b1;
    repeat (2) @(negedge CLK);
    ymode = 0; sweep0(0, 1, 4'b0000); wait_sb0();

    // HOLD_CYCLES=1 with START held: DONE in cycles 5, 11, 17
    @(negedge CLK);
    b1.START = 1'b1;
    @(posedge CLK);
    #1;
    t0_1 = cyc;
    sb1.push_back('{t0_1 + 4,  0, 1, 0});
    sb1.push_back('{t0_1 + 10, 0, 1, 0});
    sb1.push_back('{t0_1 + 16, 0, 1, 0});
    for (int i = 0; i < 100 && cyc < t0_1 + 16; i++) @(negedge CLK);
    b1.START = 1'b0;
    for (int i = 0; i < 100 && sb1.size() != 0; i++) @(negedge CLK);
    chk("done1_timeout", sb1.size(), 0);
    repeat (10) @(negedge CLK);
    chk("b2b_idle_busy", int'(b1.BUSY), 0);
    chk("b2b_pass", int'(b1.PASS), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
